// File: rtl/cordic_out_buf_pkg.sv
// ---------------------------------------------------------------------------
// cordic_out_buf_pkg
// Shared constants for the CORDIC result buffer: default result width and
// buffer depth (must track the CORDIC core build), the request mode
// encodings, and a helper that substitutes the "no mode" code when no tag is
// available for an arriving result.
// ---------------------------------------------------------------------------
package cordic_out_buf_pkg;

  localparam int CORDIC_OUT_WIDTH = 16;
  localparam int CORDIC_BUF_DEPTH = 8;

  typedef enum logic [1:0] {
    MODE_NONE   = 2'd0,
    MODE_VECTOR = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_RSVD   = 2'd3
  } cordic_mode_e;

  // Mode to store with a result: the queued tag when one exists, else 0.
  function automatic logic [1:0] tag_or_none(input logic tag_present,
                                             input logic [1:0] tag);
    logic [1:0] mode;
    if (tag_present) begin
      mode = tag;
    end else begin
      mode = MODE_NONE;
    end
    return mode;
  endfunction

endpackage

// File: rtl/cordic_sync_fifo.sv
// ---------------------------------------------------------------------------
// cordic_sync_fifo
// Generic single-clock FIFO with first-word-fall-through head output.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, wdata     write request and data (ignored while full)
//   pop             read request (ignored while empty)
//   full, empty     occupancy flags
//   level           number of stored entries (0..DEPTH)
//   rdata           head entry, valid while !empty
// Pointers are log2(DEPTH) bits and wrap naturally, so DEPTH must be a
// power of two. Storage is reset to zero so the head reads 0 after reset.
// ---------------------------------------------------------------------------
module cordic_sync_fifo
  import cordic_out_buf_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_s;
  logic             pop_s;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == {LVL_W{1'b0}});
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // Next-state: gated push/pop, storage write, pointer and level update.
  always_comb begin
    push_s   = push && !full;
    pop_s    = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1'b1);
      2'b01:   level_d = level_q - LVL_W'(1'b1);
      default: level_d = level_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/cordic_out_buf.sv
// ---------------------------------------------------------------------------
// cordic_out_buf
// Result buffer behind the CORDIC core, which has no backpressure.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   issue_in, issue_mode_in    issuer request pulse (same cycle as core en_in)
//   issue_ok                   credit available; issue only while high
//   res_valid_in/r_in/a_in     core result pulse and data
//   m_valid/m_ready            consumer handshake
//   m_mode/m_r/m_a             head result, read combinationally
//   level                      entries in the data FIFO
//   err                        sticky protocol error, cleared by reset only
// A reservation counter (rsv) counts issued-but-not-consumed results and
// caps it at DEPTH, so an accepted issue always has room by the time its
// result arrives. A tag queue carries the issue mode to the in-order result.
// ---------------------------------------------------------------------------
module cordic_out_buf
  import cordic_out_buf_pkg::*;
#(
  parameter int OUT_WIDTH = CORDIC_OUT_WIDTH,
  parameter int DEPTH     = CORDIC_BUF_DEPTH,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_in,
  input  logic [1:0]           issue_mode_in,
  output logic                 issue_ok,
  input  logic                 res_valid_in,
  input  logic [OUT_WIDTH-1:0] res_r_in,
  input  logic [OUT_WIDTH-1:0] res_a_in,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [1:0]           m_mode,
  output logic [OUT_WIDTH-1:0] m_r,
  output logic [OUT_WIDTH-1:0] m_a,
  output logic [CNT_W-1:0]     level,
  output logic                 err
);

  localparam int DATA_W = 2 + 2 * OUT_WIDTH;

  logic [CNT_W-1:0]  rsv_q, rsv_d;
  logic              err_q, err_d;

  logic              issue_acc_s;
  logic              hs_s;
  logic              tag_push_s;
  logic              tag_pop_s;
  logic              tag_full_s;
  logic              tag_empty_s;
  logic [1:0]        tag_head_s;
  logic [CNT_W-1:0]  tag_level_unused;
  logic              data_push_s;
  logic              data_full_s;
  logic              data_empty_s;
  logic [DATA_W-1:0] data_wdata_s;
  logic [DATA_W-1:0] data_head_s;

  assign issue_ok = (rsv_q < CNT_W'(DEPTH));
  assign m_valid  = !data_empty_s;
  assign m_mode   = data_head_s[DATA_W-1 -: 2];
  assign m_r      = data_head_s[2*OUT_WIDTH-1 -: OUT_WIDTH];
  assign m_a      = data_head_s[OUT_WIDTH-1:0];
  assign err      = err_q;

  // Handshake decode, FIFO controls, credit counter and error detection.
  always_comb begin
    issue_acc_s  = issue_in && issue_ok;
    hs_s         = m_valid && m_ready;
    // Tag overflow is only reachable after an earlier protocol error.
    tag_push_s   = issue_acc_s && !tag_full_s;
    tag_pop_s    = res_valid_in && !tag_empty_s;
    // A full data FIFO refuses the push even if a pop frees a slot this cycle.
    data_push_s  = res_valid_in && !data_full_s;
    data_wdata_s = {tag_or_none(!tag_empty_s, tag_head_s), res_r_in, res_a_in};

    rsv_d = rsv_q;
    case ({issue_acc_s, hs_s})
      2'b10: rsv_d = rsv_q + CNT_W'(1'b1);
      2'b01: begin
        // Untagged results (after an error) may outnumber reservations.
        if (rsv_q != {CNT_W{1'b0}}) begin
          rsv_d = rsv_q - CNT_W'(1'b1);
        end else begin
          rsv_d = rsv_q;
        end
      end
      default: rsv_d = rsv_q;
    endcase

    err_d = err_q
          | (issue_in && !issue_ok)
          | (res_valid_in && tag_empty_s)
          | (res_valid_in && data_full_s)
          | (issue_acc_s && tag_full_s);
  end

  // Credit counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsv_q <= {CNT_W{1'b0}};
      err_q <= 1'b0;
    end else begin
      rsv_q <= rsv_d;
      err_q <= err_d;
    end
  end

  cordic_sync_fifo #(
    .WIDTH (2),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tag_push_s),
    .wdata (issue_mode_in),
    .pop   (tag_pop_s),
    .full  (tag_full_s),
    .empty (tag_empty_s),
    .level (tag_level_unused),
    .rdata (tag_head_s)
  );

  cordic_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_data_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (data_push_s),
    .wdata (data_wdata_s),
    .pop   (hs_s),
    .full  (data_full_s),
    .empty (data_empty_s),
    .level (level),
    .rdata (data_head_s)
  );

endmodule

// File: tb/tb_cordic_out_buf.sv
// ---------------------------------------------------------------------------
// tb_cordic_out_buf
// Directed bench for cordic_out_buf (OUT_WIDTH=16, DEPTH=8). Inputs change
// 1 time unit after the rising edge; outputs are checked at that point.
// ---------------------------------------------------------------------------
module tb_cordic_out_buf;

  logic        clk;
  logic        rst_n;
  logic        issue_in;
  logic [1:0]  issue_mode_in;
  logic        issue_ok;
  logic        res_valid_in;
  logic [15:0] res_r_in;
  logic [15:0] res_a_in;
  logic        m_valid;
  logic        m_ready;
  logic [1:0]  m_mode;
  logic [15:0] m_r;
  logic [15:0] m_a;
  logic [3:0]  level;
  logic        err;

  int total;
  int bad;

  cordic_out_buf #(
    .OUT_WIDTH (16),
    .DEPTH     (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_in      (issue_in),
    .issue_mode_in (issue_mode_in),
    .issue_ok      (issue_ok),
    .res_valid_in  (res_valid_in),
    .res_r_in      (res_r_in),
    .res_a_in      (res_a_in),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_mode        (m_mode),
    .m_r           (m_r),
    .m_a           (m_a),
    .level         (level),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0]  exp_mode [4];
    logic [15:0] rr;
    logic [15:0] aa;
    logic [1:0]  mm;

    total = 0;
    bad   = 0;
    exp_mode[0] = 2'd2;
    exp_mode[1] = 2'd1;
    exp_mode[2] = 2'd2;
    exp_mode[3] = 2'd1;

    rst_n         = 1'b0;
    issue_in      = 1'b0;
    issue_mode_in = 2'd0;
    res_valid_in  = 1'b0;
    res_r_in      = 16'h0000;
    res_a_in      = 16'h0000;
    m_ready       = 1'b0;

    // Reset
    repeat (3) tick();
    chk("rst_issue_ok", 32'(issue_ok), 32'd1);
    chk("rst_m_valid",  32'(m_valid),  32'd0);
    chk("rst_level",    32'(level),    32'd0);
    chk("rst_err",      32'(err),      32'd0);
    chk("rst_head",     {12'd0, m_mode, m_r ^ m_a}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_issue_ok", 32'(issue_ok), 32'd1);

    // Single result
    issue_in = 1'b1; issue_mode_in = 2'd1;
    tick();
    issue_in = 1'b0;
    chk("single_rsv1", 32'(dut.rsv_q), 32'd1);
    repeat (10) tick();
    res_valid_in = 1'b1; res_r_in = 16'h1234; res_a_in = 16'h4000;
    tick();
    res_valid_in = 1'b0;
    chk("single_m_valid", 32'(m_valid), 32'd1);
    chk("single_m_mode",  32'(m_mode),  32'd1);
    chk("single_m_r",     32'(m_r),     32'h1234);
    chk("single_m_a",     32'(m_a),     32'h4000);
    chk("single_level",   32'(level),   32'd1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("single_pop_valid", 32'(m_valid),     32'd0);
    chk("single_pop_rsv",   32'(dut.rsv_q),   32'd0);
    chk("single_err",       32'(err),         32'd0);

    // Mode ordering
    for (int i = 0; i < 4; i++) begin
      issue_in = 1'b1; issue_mode_in = exp_mode[i];
      tick();
    end
    issue_in = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      res_valid_in = 1'b1; res_r_in = 16'(i + 1); res_a_in = 16'h0000;
      tick();
    end
    res_valid_in = 1'b0;
    chk("order_level", 32'(level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("order_mode", 32'(m_mode), 32'(exp_mode[i]));
      chk("order_r",    32'(m_r),    32'(i + 1));
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
    end
    chk("order_empty", 32'(m_valid), 32'd0);
    chk("order_err",   32'(err),     32'd0);

    // Wrap-around with m_ready held high
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mm = 2'((i % 2) + 1);
      rr = 16'($urandom);
      aa = 16'($urandom);
      issue_in = 1'b1; issue_mode_in = mm;
      tick();
      issue_in = 1'b0;
      res_valid_in = 1'b1; res_r_in = rr; res_a_in = aa;
      tick();
      res_valid_in = 1'b0;
      chk("wrap_valid", 32'(m_valid), 32'd1);
      chk("wrap_mode",  32'(m_mode),  32'(mm));
      chk("wrap_r",     32'(m_r),     32'(rr));
      chk("wrap_a",     32'(m_a),     32'(aa));
      chk("wrap_level", 32'(level),   32'd1);
      tick();
      chk("wrap_drained", 32'(level), 32'd0);
    end
    m_ready = 1'b0;
    chk("wrap_err", 32'(err), 32'd0);

    // Credit exhaustion
    for (int i = 0; i < 8; i++) begin
      issue_in = 1'b1; issue_mode_in = 2'd2;
      tick();
    end
    chk("credit_ok_low", 32'(issue_ok), 32'd0);
    chk("credit_err_pre", 32'(err),     32'd0);
    tick();   // 9th issue, refused
    issue_in = 1'b0;
    chk("credit_err",   32'(err),       32'd1);
    chk("credit_rsv8",  32'(dut.rsv_q), 32'd8);
    for (int i = 0; i < 8; i++) begin
      res_valid_in = 1'b1; res_r_in = 16'(i); res_a_in = 16'hA5A5;
      tick();
    end
    chk("full_level", 32'(level), 32'd8);
    chk("full_head",  32'(m_r),   32'd0);
    // Push on a full FIFO together with a pop: push dropped, pop done.
    res_r_in = 16'hDEAD; m_ready = 1'b1;
    tick();
    res_valid_in = 1'b0; m_ready = 1'b0;
    chk("full_pushpop_level", 32'(level),       32'd7);
    chk("release_issue_ok",   32'(issue_ok),    32'd1);
    chk("release_rsv",        32'(dut.rsv_q),   32'd7);
    chk("release_head",       32'(m_r),         32'd1);
    m_ready = 1'b1;
    repeat (6) tick();
    chk("last_head_r", 32'(m_r), 32'd7);
    tick();
    m_ready = 1'b0;
    chk("drain_level", 32'(level),     32'd0);
    chk("drain_rsv",   32'(dut.rsv_q), 32'd0);
    chk("err_sticky",  32'(err),       32'd1);

    // Reset mid-operation with 5 entries buffered
    for (int i = 0; i < 5; i++) begin
      issue_in = 1'b1; issue_mode_in = 2'd1;
      tick();
    end
    issue_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      res_valid_in = 1'b1; res_r_in = 16'(i + 16'h100); res_a_in = 16'h0001;
      tick();
    end
    res_valid_in = 1'b0;
    chk("mid_level5", 32'(level), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",    32'(m_valid),  32'd0);
    chk("mid_rst_level",    32'(level),    32'd0);
    chk("mid_rst_issue_ok", 32'(issue_ok), 32'd1);
    chk("mid_rst_err",      32'(err),      32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rel_valid", 32'(m_valid),     32'd0);
    chk("mid_rel_rsv",   32'(dut.rsv_q),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
